// File: rtl/eth_xfer_ctrl.sv
// Host-commanded burst mover: streams inbound words into banked memory or reads a
// burst out of memory through a 2-entry prefetch FIFO onto the outbound stream.
module eth_xfer_ctrl #(
    parameter int unsigned BURST_LEN = 128,
    parameter int unsigned NUM_PROC  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Command0,
    output logic [31:0] Status0,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [2:0]  mem_proc_sel,
    output logic [3:0]  mem_top_sel,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic        mem_re,
    input  logic [63:0] mem_rdata
);

    localparam logic [11:0] LAST_IDX = 12'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_prev_q;
    logic [2:0]  proc_q;
    logic [3:0]  top_q;
    logic [10:0] base_q;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] sent_q;
    logic [1:0]  err_q, err_d;
    logic        rd_mode_q, rd_mode_d;
    logic        inflight_q;
    logic [63:0] fifo_mem [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  fifo_cnt_q;

    logic [7:0]  opcode;
    logic        cmd_edge;
    logic        latch;
    logic        clr_cnt;
    logic        push;
    logic        pop;
    logic [2:0]  occ;
    logic        busy;
    logic        done;
    logic        unused_cmd_bits;

    assign opcode          = Command0[31:24];
    assign cmd_edge        = (op_prev_q == 8'd0) && (opcode != 8'd0);
    assign unused_cmd_bits = &{1'b0, Command0[23], Command0[15:11]};

    assign push          = inflight_q;
    assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign m_axis_tdata  = fifo_mem[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && (sent_q == LAST_IDX);
    assign pop           = m_axis_tvalid && m_axis_tready;

    // Occupancy counts the word leaving this cycle as already gone so a
    // continuously ready sink sees one word per cycle.
    assign occ = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign mem_proc_sel = proc_q;
    assign mem_top_sel  = top_q;
    assign mem_wdata    = s_axis_tdata;

    assign busy    = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign Status0 = {busy, done, err_q, 16'h0000, (rd_mode_q ? sent_q : cnt_q)};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        rd_mode_d     = rd_mode_q;
        latch         = 1'b0;
        clr_cnt       = 1'b0;
        s_axis_tready = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_addr      = base_q + cnt_q[10:0];

        case (state_q)
            S_IDLE: begin
                if (cmd_edge) begin
                    cnt_d   = '0;
                    clr_cnt = 1'b1;
                    if ((opcode == 8'd1) || (opcode == 8'd2)) begin
                        latch     = 1'b1;
                        rd_mode_d = (opcode == 8'd2);
                        if ({29'd0, Command0[22:20]} >= NUM_PROC) begin
                            err_d   = 2'b01;
                            state_d = S_DONE;
                        end else begin
                            err_d   = 2'b00;
                            state_d = (opcode == 8'd1) ? S_WRITE : S_READ;
                        end
                    end else begin
                        rd_mode_d = 1'b0;
                        err_d     = 2'b10;
                        state_d   = S_DONE;
                    end
                end
            end

            S_WRITE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 12'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                        err_d   = s_axis_tlast ? 2'b00 : 2'b11;
                    end else if (s_axis_tlast) begin
                        state_d = S_DONE;
                        err_d   = 2'b11;
                    end
                end
            end

            S_READ: begin
                if (occ < 3'd2) begin
                    mem_re = 1'b1;
                    cnt_d  = cnt_q + 12'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (pop && (sent_q == LAST_IDX)) begin
                    state_d = S_DONE;
                    err_d   = 2'b00;
                end
            end

            S_DONE: begin
                if (opcode == 8'd0) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_prev_q  <= '0;
            proc_q     <= '0;
            top_q      <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            sent_q     <= '0;
            err_q      <= '0;
            rd_mode_q  <= 1'b0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_prev_q  <= opcode;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_mode_q  <= rd_mode_d;
            inflight_q <= mem_re;
            if (latch) begin
                proc_q <= Command0[22:20];
                top_q  <= Command0[19:16];
                base_q <= Command0[10:0];
            end
            if (clr_cnt) begin
                sent_q <= '0;
            end else if (pop) begin
                sent_q <= sent_q + 12'd1;
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: doc/eth_xfer_ctrl.md
ETH_XFER_CTRL -- requirements
Module: eth_xfer_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 128, words per command burst (power of 2, 2..2048).
REQ-002 Parameter NUM_PROC, default 7, valid processor_sel range 0..NUM_PROC-1.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 Command0  in  32  host command: [31:24] opcode (0 idle, 1 host->mem write, 2 mem->host read), [22:20] processor_sel, [19:16] top_mem_sel, [10:0] base address; other bits ignored.
REQ-006 Status0  out  32  [31] busy, [30] done, [29:28] err code, [27:16] zero, [11:0] words transferred in current/last command.
REQ-007 s_axis_tdata/tvalid/tlast  in  64/1/1  inbound stream; s_axis_tready out 1.
REQ-008 m_axis_tdata/tvalid/tlast  out  64/1/1  outbound stream; m_axis_tready in 1.
REQ-009 mem_proc_sel out 3, mem_top_sel out 4, mem_addr out 11, mem_we out 1, mem_wdata out 64, mem_re out 1, mem_rdata in 64 (valid exactly 1 cycle after mem_re).

Function
REQ-010 States IDLE, WRITE, READ, DRAIN, DONE; exactly one active.
REQ-011 IDLE: command latched when opcode in {1,2} and previous-cycle opcode was 0 (edge); proc/top/base captured into registers, word counter cleared.
REQ-012 Latched processor_sel >= NUM_PROC: no memory access, err=2'b01, go DONE next cycle.
REQ-013 Opcode not in {0,1,2} on edge: err=2'b10, go DONE.
REQ-014 WRITE: s_axis_tready=1; each tvalid&tready beat drives mem_we=1, mem_wdata=tdata, mem_addr=(base+count) mod 2048 same cycle (combinational from registered count); count increments.
REQ-015 WRITE: tlast on beat count==BURST_LEN-1 -> DONE, err=0; tlast earlier -> DONE, err=2'b11, count reflects beats written.
REQ-016 WRITE: beat BURST_LEN-1 without tlast -> word still written, DONE, err=2'b11.
REQ-017 READ: mem_re issued at (base+rd_count) mod 2048 only when fifo_count + inflight < 2; rd_count increments per mem_re; after BURST_LEN issues go DRAIN.
REQ-018 Read data captured one cycle after mem_re into 2-entry output FIFO; FIFO never overflows; no word dropped or duplicated under any m_axis_tready pattern.
REQ-019 m_axis_tvalid = FIFO non-empty; tdata = FIFO head; tdata/tlast stable while tvalid&!tready.
REQ-020 m_axis_tlast=1 exactly on output word BURST_LEN-1; sent-word counter drives Status0[11:0] in READ/DRAIN.
REQ-021 DRAIN: leave to DONE on cycle after last word handshake; err=0.
REQ-022 Full-throughput: with tready held 1, one word per cycle after 2-cycle initial latency (mem_re cycle 0 -> tvalid cycle 2).
REQ-023 DONE: done=1, busy=0, no stream handshakes (tready=0, tvalid=0); return to IDLE when opcode==0, clearing done; err held until next command latched.
REQ-024 busy=1 in WRITE, READ, DRAIN.
REQ-025 Opcode change while busy ignored; command runs to completion.
REQ-026 mem_proc_sel/mem_top_sel held at latched values from latch until next latch.
REQ-027 Address wrap: base 2047 + 1 -> 0, no error.
REQ-028 mem_we and mem_re never both 1; both 0 outside WRITE/READ.

Reset
REQ-029 rst=1 at any edge: state IDLE, Status0=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, mem_we=0, mem_re=0, FIFO emptied, counters 0, opcode history 0 (opcode held nonzero through reset release starts a command).
REQ-030 rst mid-transfer aborts immediately; in-flight read data discarded; no partial-state output next cycle.

Verification
REQ-031 Write: Command0=0x0104_0080 (proc 0, top 4, base 128), 128 beats, tlast on 128th -> mem_we at addrs 128..255 in order, Status0=0x4000_0080, then opcode 0 -> Status0[30]=0.
REQ-032 Read, tready=1: opcode 2, proc 6, base 1920 -> 128 words from addrs 1920..2047, tvalid 2 cycles after first mem_re, contiguous, tlast on word 127.
REQ-033 Read, tready random 50% + 10-cycle stall -> output sequence identical to memory contents, no loss/duplication, mem_re never exceeds FIFO space.
REQ-034 Write, tlast on beat 60 -> 60 writes, err=2'b11, Status0[11:0]=60; base 2000 wrap check: writes 2000..2047 then 0..11.
REQ-035 processor_sel=7 -> no mem_we/mem_re, Status0=0x5000_0000; opcode 3 -> err 2'b10.
REQ-036 rst pulse at read word 50 -> next cycle all outputs at reset values; fresh command afterwards completes normally.
